// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin share of one 8N1 UART transmit line
// among N_REQ byte producers; the grant is held for a whole frame.
module uart_tx_arbiter #(
    parameter int CLK_HZ = 48000000,
    parameter int BAUD   = 115200,
    parameter int N_REQ  = 2
) (
    input  logic                                      clk,
    input  logic                                      resetn,
    input  logic [N_REQ-1:0]                          req_valid,
    input  logic [8*N_REQ-1:0]                        req_data,
    output logic [N_REQ-1:0]                          req_ready,
    output logic                                      busy,
    output logic [(N_REQ > 1 ? $clog2(N_REQ) : 1)-1:0] tx_owner,
    output logic                                      uart_txd
);

    localparam int OW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CPB = CLK_HZ / BAUD;
    localparam int CW  = $clog2(CPB);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_baud;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic [OW-1:0] r_owner;
    logic [OW-1:0] r_last;

    logic          w_tick;
    logic          w_found;
    logic          w_accept;
    logic [OW-1:0] w_win;
    logic [7:0]    w_byte;
    int            w_idx;

    assign w_tick   = (r_baud == CW'(CPB - 1));
    assign w_accept = (r_state == S_IDLE) && resetn && w_found;
    assign tx_owner = r_owner;

    // Round-robin winner: scan upward from the slot after the last owner.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_byte  = '0;
        w_idx   = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_idx = (int'(r_last) + k) % N_REQ;
            if (!w_found && req_valid[w_idx]) begin
                w_found = 1'b1;
                w_win   = OW'(w_idx);
                w_byte  = req_data[8*w_idx +: 8];
            end
        end
    end

    // One-hot ready, only for the winner while idle and out of reset.
    always_comb begin
        req_ready = '0;
        if (w_accept) begin
            req_ready[w_win] = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state: each bit phase ends on the baud terminal count.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_START;
            S_START: if (w_tick) w_next = S_DATA;
            S_DATA:  if (w_tick && r_bit == 3'd7) w_next = S_STOP;
            S_STOP:  if (w_tick) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Baud/bit counters, shift register and owner tracking.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_owner <= '0;
            r_last  <= OW'(N_REQ - 1);
        end else begin
            if (r_state == S_IDLE || w_tick) begin
                r_baud <= '0;
            end else begin
                r_baud <= r_baud + 1'b1;
            end
            if (w_accept) begin
                r_shift <= w_byte;
                r_owner <= w_win;
                r_last  <= w_win;
                r_bit   <= '0;
            end else if (r_state == S_DATA && w_tick) begin
                r_shift <= {1'b0, r_shift[7:1]};
                r_bit   <= r_bit + 1'b1;
            end
        end
    end

    // Line and busy decode from the current state; line idles high.
    always_comb begin
        busy     = (r_state != S_IDLE);
        uart_txd = 1'b1;
        case (r_state)
            S_START: uart_txd = 1'b0;
            S_DATA:  uart_txd = r_shift[0];
            default: uart_txd = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: vector table, directed corner sequences and
// random traffic against a frame-level reference model.
module tb_uart_tx_arbiter;

    localparam int CPB = 4;
    localparam int N   = 2;
    localparam int FL  = 10 * CPB;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [15:0] req_data = '0;
    logic [1:0]  req_ready;
    logic        busy;
    logic [0:0]  tx_owner;
    logic        uart_txd;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .CLK_HZ(16),
        .BAUD  (4),
        .N_REQ (N)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .req_valid(req_valid),
        .req_data (req_data),
        .req_ready(req_ready),
        .busy     (busy),
        .tx_owner (tx_owner),
        .uart_txd (uart_txd)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h",
                     nm, $time, act, exp);
        end
    endtask

    typedef struct {
        logic       rst;
        logic [1:0] v;
        logic [7:0] d0;
        logic [7:0] d1;
        int         n;
        logic [1:0] rdy;
        logic       bsy;
        logic       txd;
        logic       own;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(logic rst, logic [1:0] v, logic [7:0] d0,
                                logic [7:0] d1, int n, logic [1:0] rdy,
                                logic bsy, logic txd, logic own);
        vec_t e;
        e.rst = rst;
        e.v   = v;
        e.d0  = d0;
        e.d1  = d1;
        e.n   = n;
        e.rdy = rdy;
        e.bsy = bsy;
        e.txd = txd;
        e.own = own;
        tbl.push_back(e);
    endfunction

    // A whole frame on the line: start, 8 data bits LSB first, stop.
    function automatic void add_frame(logic [1:0] v, logic [7:0] d0,
                                      logic [7:0] d1, logic [7:0] b,
                                      logic own);
        add(1'b1, v, d0, d1, CPB, 2'b00, 1'b1, 1'b0, own);
        for (int k = 0; k < 8; k++) begin
            add(1'b1, v, d0, d1, CPB, 2'b00, 1'b1, b[k], own);
        end
        add(1'b1, v, d0, d1, CPB, 2'b00, 1'b1, 1'b1, own);
    endfunction

    // Reference model: a frame is 10 symbols of CPB cycles each.
    int         m_left;
    int         m_el;
    int         m_last;
    int         m_owner;
    int         m_acc;
    logic [9:0] m_frame;

    task automatic model_reset();
        m_left  = 0;
        m_el    = 0;
        m_last  = N - 1;
        m_owner = 0;
        m_acc   = -1;
        m_frame = '1;
    endtask

    task automatic cyc(logic r, logic [1:0] v, logic [15:0] d);
        int w;
        int j;
        logic [1:0] er;
        logic et;
        @(negedge clk);
        resetn    = r;
        req_valid = v;
        req_data  = d;
        w = -1;
        if (m_left == 0 && r) begin
            for (int k = 1; k <= N; k++) begin
                j = (m_last + k) % N;
                if (w < 0 && v[j]) w = j;
            end
        end
        er = '0;
        if (w >= 0) er[w] = 1'b1;
        et = (m_left == 0) ? 1'b1 : m_frame[m_el / CPB];
        #1;
        chk("ready", 8'(req_ready), 8'(er));
        chk("busy", 8'(busy), 8'(m_left > 0));
        chk("txd", 8'(uart_txd), 8'(et));
        chk("owner", 8'(tx_owner), 8'(m_owner));
        @(posedge clk);
        m_acc = -1;
        if (!r) begin
            model_reset();
        end else if (m_left == 0) begin
            if (w >= 0) begin
                m_frame = {1'b1, d[8*w +: 8], 1'b0};
                m_el    = 0;
                m_left  = FL;
                m_last  = w;
                m_owner = w;
                m_acc   = w;
            end
        end else begin
            m_el++;
            m_left--;
        end
    endtask

    logic [1:0]  pv;
    logic [15:0] pd;
    logic        rr;

    initial begin
        add(1'b0, 2'b01, 8'hA5, 8'h00, 3, 2'b00, 1'b0, 1'b1, 1'b0);
        add(1'b1, 2'b01, 8'hA5, 8'h00, 1, 2'b01, 1'b0, 1'b1, 1'b0);
        add_frame(2'b00, 8'hA5, 8'h00, 8'hA5, 1'b0);
        add(1'b1, 2'b00, 8'hA5, 8'h00, 2, 2'b00, 1'b0, 1'b1, 1'b0);
        add(1'b0, 2'b11, 8'h11, 8'h22, 1, 2'b00, 1'b0, 1'b1, 1'b0);
        add(1'b1, 2'b11, 8'h11, 8'h22, 1, 2'b01, 1'b0, 1'b1, 1'b0);
        add_frame(2'b11, 8'h11, 8'h22, 8'h11, 1'b0);
        add(1'b1, 2'b11, 8'h11, 8'h22, 1, 2'b10, 1'b0, 1'b1, 1'b0);
        add_frame(2'b11, 8'h11, 8'h22, 8'h22, 1'b1);
        add(1'b1, 2'b11, 8'h11, 8'h22, 1, 2'b01, 1'b0, 1'b1, 1'b1);
        add_frame(2'b11, 8'h11, 8'h22, 8'h11, 1'b0);
        add(1'b1, 2'b11, 8'h11, 8'h22, 1, 2'b10, 1'b0, 1'b1, 1'b0);

        foreach (tbl[i]) begin
            for (int c = 0; c < tbl[i].n; c++) begin
                @(negedge clk);
                resetn    = tbl[i].rst;
                req_valid = tbl[i].v;
                req_data  = {tbl[i].d1, tbl[i].d0};
                #1;
                chk($sformatf("tbl%0d_ready", i), 8'(req_ready), 8'(tbl[i].rdy));
                chk($sformatf("tbl%0d_busy", i), 8'(busy), 8'(tbl[i].bsy));
                chk($sformatf("tbl%0d_txd", i), 8'(uart_txd), 8'(tbl[i].txd));
                chk($sformatf("tbl%0d_owner", i), 8'(tx_owner), 8'(tbl[i].own));
            end
        end

        @(negedge clk);
        resetn    = 1'b0;
        req_valid = '0;
        @(negedge clk);
        model_reset();

        // Data changed right after accept must not reach the line.
        cyc(1'b0, 2'b00, 16'h0000);
        cyc(1'b1, 2'b01, 16'h003C);
        for (int c = 0; c < FL + 2; c++) cyc(1'b1, 2'b00, 16'h00FF);

        // Reset during data bit 3 abandons the frame.
        cyc(1'b1, 2'b10, 16'h9600);
        for (int c = 0; c < CPB + 3 * CPB + 1; c++) cyc(1'b1, 2'b00, 16'h0000);
        cyc(1'b0, 2'b01, 16'h005A);
        cyc(1'b0, 2'b01, 16'h005A);
        cyc(1'b1, 2'b01, 16'h005A);
        for (int c = 0; c < FL + 3; c++) cyc(1'b1, 2'b00, 16'h0000);

        // Requester 1 withdraws before the line goes idle.
        cyc(1'b1, 2'b01, 16'h00C3);
        for (int c = 0; c < 20; c++) cyc(1'b1, 2'b00, 16'h0000);
        for (int c = 0; c < 10; c++) cyc(1'b1, 2'b10, 16'h7700);
        for (int c = 0; c < 16; c++) cyc(1'b1, 2'b00, 16'h7700);

        // Random traffic obeying the hold-until-accepted rule.
        pv = '0;
        pd = '0;
        for (int t = 0; t < 4000; t++) begin
            rr = ($urandom_range(0, 499) != 0);
            for (int i = 0; i < N; i++) begin
                if (!pv[i] && $urandom_range(0, 5) == 0) begin
                    pv[i] = 1'b1;
                    pd[8*i +: 8] = 8'($urandom);
                end else if (pv[i] && $urandom_range(0, 79) == 0) begin
                    pv[i] = 1'b0;
                end
            end
            cyc(rr, pv, pd);
            if (m_acc >= 0) pv[m_acc] = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
